// File: rtl/fw_ctrl_pkg.sv
// Shared types and encodings for the Floyd-Warshall phase sequencer.
package fw_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RELAX,
        S_DONE,
        S_ERR
    } fw_state_e;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_INIT  = 2'd1;
    localparam logic [1:0] PH_RELAX = 2'd2;
    localparam logic [1:0] PH_END   = 2'd3;

    // Host-visible phase code for a controller state.
    function automatic logic [1:0] phase_of(input fw_state_e s);
        case (s)
            S_INIT:         phase_of = PH_INIT;
            S_RELAX:        phase_of = PH_RELAX;
            S_DONE, S_ERR:  phase_of = PH_END;
            default:        phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fw_phase_timer.sv
// Saturating per-phase cycle counter with a watchdog compare. Loading 1 on
// clear makes the count equal the number of cycles spent in the phase.
module fw_phase_timer
    import fw_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load on phase entry, otherwise increment and stick at all-ones.
    always_comb begin
        // NOTE: default first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (limit_i != '0) && (count_q == limit_i);

endmodule

// File: rtl/fw_phase_sequencer.sv
// Block-level ap_ctrl_hs controller: runs the init child then the relaxation
// child, holds each child start until accepted, times each phase and aborts
// a phase whose watchdog expires.
module fw_phase_sequencer
    import fw_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             init_start,
    input  logic             init_ready,
    input  logic             init_done,
    output logic             relax_start,
    input  logic             relax_ready,
    input  logic             relax_done,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic             err,
    output logic [1:0]       err_phase,
    output logic [CNT_W-1:0] init_cycles,
    output logic [CNT_W-1:0] relax_cycles,
    output logic [1:0]       phase
);

    fw_state_e        state_q;
    logic             start_pending_q;
    logic             err_q;
    logic [1:0]       err_phase_q;
    logic [CNT_W-1:0] timeout_q;
    logic [CNT_W-1:0] init_cycles_q;
    logic [CNT_W-1:0] relax_cycles_q;

    logic             timer_clear;
    logic             timer_enable;
    logic [CNT_W-1:0] phase_count;
    logic             phase_expired;

    // The timer restarts on entry to each phase and runs while in a phase.
    assign timer_clear  = ((state_q == S_IDLE) && ap_start) ||
                          ((state_q == S_INIT) && init_done);
    assign timer_enable = (state_q == S_INIT) || (state_q == S_RELAX);

    fw_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i     (ap_clk),
        .rst_ni    (ap_rst_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .limit_i   (timeout_q),
        .count_o   (phase_count),
        .expired_o (phase_expired)
    );

    // Sequencer FSM with its handshake, error and cycle-count registers.
    // A child done beats a watchdog expiry in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= S_IDLE;
            start_pending_q <= 1'b0;
            err_q           <= 1'b0;
            err_phase_q     <= PH_IDLE;
            timeout_q       <= '0;
            init_cycles_q   <= '0;
            relax_cycles_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q         <= S_INIT;
                        start_pending_q <= 1'b1;
                        err_q           <= 1'b0;
                        err_phase_q     <= PH_IDLE;
                        timeout_q       <= timeout_cycles;
                        init_cycles_q   <= '0;
                        relax_cycles_q  <= '0;
                    end
                end
                S_INIT: begin
                    init_cycles_q <= phase_count;
                    if (init_done) begin
                        state_q         <= S_RELAX;
                        start_pending_q <= 1'b1;
                    end else if (phase_expired) begin
                        state_q         <= S_ERR;
                        start_pending_q <= 1'b0;
                        err_q           <= 1'b1;
                        err_phase_q     <= PH_INIT;
                    end else if (init_ready) begin
                        start_pending_q <= 1'b0;
                    end
                end
                S_RELAX: begin
                    relax_cycles_q <= phase_count;
                    if (relax_done) begin
                        state_q         <= S_DONE;
                        start_pending_q <= 1'b0;
                    end else if (phase_expired) begin
                        state_q         <= S_ERR;
                        start_pending_q <= 1'b0;
                        err_q           <= 1'b1;
                        err_phase_q     <= PH_RELAX;
                    end else if (relax_ready) begin
                        start_pending_q <= 1'b0;
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q         <= S_IDLE;
                    start_pending_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    assign ap_idle      = (state_q == S_IDLE);
    assign ap_done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign ap_ready     = ap_done;
    assign init_start   = (state_q == S_INIT)  && start_pending_q;
    assign relax_start  = (state_q == S_RELAX) && start_pending_q;
    assign err          = err_q;
    assign err_phase    = err_phase_q;
    assign init_cycles  = init_cycles_q;
    assign relax_cycles = relax_cycles_q;
    assign phase        = phase_of(state_q);

endmodule
